// File: rtl/program_loader.sv
// program_loader: streams a bytecode program into on-chip instruction memory,
// appends a halt terminator, waits a fixed start delay, then enables the CPU.
// The CPU fetches through a registered read port that is live in every state.
module program_loader #(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 1024,
  parameter logic [DATA_W-1:0] HALT_WORD   = '1,
  parameter int                START_DELAY = 5,
  localparam int               ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_enable,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_TERM = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;

  // The delay counter only has to reach START_DELAY-1.
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] wr_addr;
  logic [DLY_W-1:0]  delay_cnt;
  logic              accept;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // The last slot is never offered to the stream so the terminator always fits.
  assign in_ready = (state == S_LOAD) && (wr_addr < LAST_ADDR);
  assign accept   = in_valid && in_ready;

  // Pick what goes into memory this cycle: a program word or the terminator.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = in_data;
    if (!rst) begin
      if (state == S_LOAD && accept) begin
        mem_we = 1'b1;
      end else if (state == S_TERM) begin
        mem_we    = 1'b1;
        mem_wdata = HALT_WORD;
      end
    end
  end

  // Memory contents survive reset so a loaded program is not lost.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= mem_wdata;
    end
  end

  // Registered fetch; a same-cycle write to the same address returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data <= '0;
    end else begin
      fetch_data <= mem[fetch_addr];
    end
  end

  // Load sequencing: stream words, append the terminator, wait, then run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_addr    <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      cpu_enable <= 1'b0;
      load_done  <= 1'b0;
      delay_cnt  <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (load_start) begin
            state      <= S_LOAD;
            wr_addr    <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            cpu_enable <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wr_addr    <= wr_addr + ADDR_ONE;
            word_count <= word_count + CNT_ONE;
            if (in_last) begin
              state <= S_TERM;
            end
          end else if (wr_addr == LAST_ADDR) begin
            overflow <= 1'b1;
            state    <= S_TERM;
          end
        end
        S_TERM: begin
          word_count <= word_count + CNT_ONE;
          delay_cnt  <= '0;
          if (START_DELAY == 0) begin
            state      <= S_RUN;
            cpu_enable <= 1'b1;
            load_done  <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (delay_cnt == DLY_LAST) begin
            state      <= S_RUN;
            cpu_enable <= 1'b1;
            load_done  <= 1'b1;
          end else begin
            delay_cnt <= delay_cnt + DLY_ONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed tests for program_loader (DEPTH = 8).
// dut uses START_DELAY = 5; dutz uses START_DELAY = 0.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [2:0] fetch_addr = 3'd0;
  logic [7:0] fetch_data;
  logic       cpu_enable;
  logic       load_done;
  logic       overflow;
  logic [3:0] word_count;

  logic       z_load_start = 1'b0;
  logic       z_in_valid = 1'b0;
  logic [7:0] z_in_data = 8'h00;
  logic       z_in_last = 1'b0;
  logic       z_in_ready;
  logic [2:0] z_fetch_addr = 3'd0;
  logic [7:0] z_fetch_data;
  logic       z_cpu_enable;
  logic       z_load_done;
  logic       z_overflow;
  logic [3:0] z_word_count;

  int compared = 0;
  int mismatched = 0;

  program_loader #(.DATA_W(8), .DEPTH(8), .HALT_WORD(8'hFF), .START_DELAY(5)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .cpu_enable(cpu_enable),
    .load_done(load_done), .overflow(overflow), .word_count(word_count)
  );

  program_loader #(.DATA_W(8), .DEPTH(8), .HALT_WORD(8'hFF), .START_DELAY(0)) dutz (
    .clk(clk), .rst(rst), .load_start(z_load_start), .in_valid(z_in_valid),
    .in_data(z_in_data), .in_last(z_in_last), .in_ready(z_in_ready),
    .fetch_addr(z_fetch_addr), .fetch_data(z_fetch_data), .cpu_enable(z_cpu_enable),
    .load_done(z_load_done), .overflow(z_overflow), .word_count(z_word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input logic last, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_mem(input logic [2:0] a, output logic [7:0] d);
    fetch_addr = a;
    tick();
    d = fetch_data;
  endtask

  task automatic wait_run(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_enable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); end
    compared++; if (cpu_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cpu_enable: got %b, expected 0", cpu_enable); end
    compared++; if (load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_load_done: got %b, expected 0", load_done); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b, expected 0", overflow); end
    compared++; if (word_count !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_word_count: got %0d, expected 0", word_count); end
    compared++; if (fetch_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_fetch_data: got %h, expected 00", fetch_data); end
    compared++; if (z_cpu_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_z_cpu_enable: got %b, expected 0", z_cpu_enable); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    logic [7:0] exp_mem [4] = '{8'h11, 8'h22, 8'h33, 8'hFF};
    logic [7:0] d;
    bit ok;
    int first_en;
    int pulses;
    pulse_start();
    send_word(8'h11, 1'b0, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_accept0: got %b, expected 1", ok); end
    send_word(8'h22, 1'b0, ok);
    send_word(8'h33, 1'b1, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_accept2: got %b, expected 1", ok); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_ready_after_last: got %b, expected 0", in_ready); end
    first_en = 0;
    pulses   = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (cpu_enable && first_en == 0) first_en = t;
      if (load_done) pulses++;
    end
    compared++; if (first_en !== 6) begin mismatched++; $display("[TB] FAIL basic_enable_cycle: got %0d, expected 6", first_en); end
    compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL basic_load_done_pulses: got %0d, expected 1", pulses); end
    compared++; if (word_count !== 4'd4) begin mismatched++; $display("[TB] FAIL basic_word_count: got %0d, expected 4", word_count); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_overflow: got %b, expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      read_mem(3'(i), d);
      compared++; if (d !== exp_mem[i]) begin mismatched++; $display("[TB] FAIL basic_mem[%0d]: got %h, expected %h", i, d, exp_mem[i]); end
    end
    compared++; if (cpu_enable !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_run_hold: got %b, expected 1", cpu_enable); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    bit ok;
    bit acc_now;
    bit ready_when_full;
    int acc;
    acc = 0;
    ready_when_full = 1'b0;
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc < 10);
      in_data  = 8'hA0 + 8'(acc);
      if (acc == 7 && in_ready) ready_when_full = 1'b1;
      acc_now = in_valid && in_ready;
      tick();
      if (acc_now) acc++;
    end
    in_valid = 1'b0;
    compared++; if (acc !== 7) begin mismatched++; $display("[TB] FAIL ovf_accepted: got %0d, expected 7", acc); end
    compared++; if (ready_when_full !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_ready_when_full: got %b, expected 0", ready_when_full); end
    wait_run(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_run_timeout: got %b, expected 1", ok); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_flag: got %b, expected 1", overflow); end
    compared++; if (word_count !== 4'd8) begin mismatched++; $display("[TB] FAIL ovf_word_count: got %0d, expected 8", word_count); end
    for (int i = 0; i < 7; i++) begin
      read_mem(3'(i), d);
      compared++; if (d !== 8'hA0 + 8'(i)) begin mismatched++; $display("[TB] FAIL ovf_mem[%0d]: got %h, expected %h", i, d, 8'hA0 + 8'(i)); end
    end
    read_mem(3'd7, d);
    compared++; if (d !== 8'hFF) begin mismatched++; $display("[TB] FAIL ovf_mem[7]: got %h, expected ff", d); end
  endtask

  task automatic test_gapped_valid();
    logic [15:0] pat = 16'b1011_0010_0110_1001;
    logic [7:0] d;
    bit ok;
    bit acc_now;
    int idx;
    idx = 0;
    pulse_start();
    for (int c = 0; c < 40 && idx < 5; c++) begin
      in_valid = pat[c % 16];
      in_data  = in_valid ? 8'hB0 + 8'(idx) : 8'hEE;
      in_last  = in_valid ? (idx == 4) : 1'b1;
      acc_now  = in_valid && in_ready;
      tick();
      if (acc_now) idx++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_run(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL gap_run_timeout: got %b, expected 1", ok); end
    compared++; if (word_count !== 4'd6) begin mismatched++; $display("[TB] FAIL gap_word_count: got %0d, expected 6", word_count); end
    for (int i = 0; i < 5; i++) begin
      read_mem(3'(i), d);
      compared++; if (d !== 8'hB0 + 8'(i)) begin mismatched++; $display("[TB] FAIL gap_mem[%0d]: got %h, expected %h", i, d, 8'hB0 + 8'(i)); end
    end
    read_mem(3'd5, d);
    compared++; if (d !== 8'hFF) begin mismatched++; $display("[TB] FAIL gap_mem[5]: got %h, expected ff", d); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    bit ok;
    bit enable_seen;
    pulse_start();
    compared++; if (cpu_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_enable_drop: got %b, expected 0", cpu_enable); end
    send_word(8'hD0, 1'b0, ok);
    send_word(8'hD1, 1'b0, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_in_ready: got %b, expected 0", in_ready); end
    compared++; if (word_count !== 4'd0) begin mismatched++; $display("[TB] FAIL abort_word_count: got %0d, expected 0", word_count); end
    enable_seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (cpu_enable) enable_seen = 1'b1;
      tick();
    end
    compared++; if (enable_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_enable_stays_low: got %b, expected 0", enable_seen); end
    read_mem(3'd0, d);
    compared++; if (d !== 8'hD0) begin mismatched++; $display("[TB] FAIL abort_mem[0]: got %h, expected d0", d); end
    read_mem(3'd1, d);
    compared++; if (d !== 8'hD1) begin mismatched++; $display("[TB] FAIL abort_mem[1]: got %h, expected d1", d); end
    read_mem(3'd2, d);
    compared++; if (d !== 8'hB2) begin mismatched++; $display("[TB] FAIL abort_mem[2]: got %h, expected b2", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tail [5] = '{8'hF3, 8'hF4, 8'hFF, 8'hA6, 8'hFF};
    logic [7:0] d;
    bit ok;
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(8'hF0 + 8'(i), i == 4, ok);
    wait_run(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_first_run: got %b, expected 1", ok); end
    tick();
    pulse_start();
    compared++; if (cpu_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_enable_drop: got %b, expected 0", cpu_enable); end
    send_word(8'hC0, 1'b0, ok);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready_second: got %b, expected 1", in_ready); end
    in_valid   = 1'b1;
    in_data    = 8'hC1;
    in_last    = 1'b1;
    load_start = 1'b1;
    tick();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    load_start = 1'b0;
    wait_run(ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_second_run: got %b, expected 1", ok); end
    compared++; if (word_count !== 4'd3) begin mismatched++; $display("[TB] FAIL b2b_word_count: got %0d, expected 3", word_count); end
    read_mem(3'd0, d);
    compared++; if (d !== 8'hC0) begin mismatched++; $display("[TB] FAIL b2b_mem[0]: got %h, expected c0", d); end
    read_mem(3'd1, d);
    compared++; if (d !== 8'hC1) begin mismatched++; $display("[TB] FAIL b2b_mem[1]: got %h, expected c1", d); end
    read_mem(3'd2, d);
    compared++; if (d !== 8'hFF) begin mismatched++; $display("[TB] FAIL b2b_mem[2]: got %h, expected ff", d); end
    for (int i = 3; i < 8; i++) begin
      read_mem(3'(i), d);
      compared++; if (d !== exp_tail[i-3]) begin mismatched++; $display("[TB] FAIL b2b_mem[%0d]: got %h, expected %h", i, d, exp_tail[i-3]); end
    end
  endtask

  task automatic test_fetch_collision();
    logic [7:0] d;
    bit ok;
    pulse_start();
    send_word(8'h47, 1'b0, ok);
    fetch_addr = 3'd1;
    in_valid   = 1'b1;
    in_data    = 8'h48;
    in_last    = 1'b1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL coll_ready: got %b, expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    compared++; if (fetch_data !== 8'hC1) begin mismatched++; $display("[TB] FAIL coll_old_data: got %h, expected c1", fetch_data); end
    tick();
    compared++; if (fetch_data !== 8'h48) begin mismatched++; $display("[TB] FAIL coll_new_data: got %h, expected 48", fetch_data); end
    wait_run(ok);
    compared++; if (word_count !== 4'd3) begin mismatched++; $display("[TB] FAIL coll_word_count: got %0d, expected 3", word_count); end
    read_mem(3'd0, d);
    compared++; if (d !== 8'h47) begin mismatched++; $display("[TB] FAIL coll_mem[0]: got %h, expected 47", d); end
  endtask

  task automatic test_zero_delay();
    z_load_start = 1'b1;
    tick();
    z_load_start = 1'b0;
    z_in_valid   = 1'b1;
    z_in_data    = 8'h5A;
    z_in_last    = 1'b1;
    compared++; if (z_in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL zd_ready: got %b, expected 1", z_in_ready); end
    tick();
    z_in_valid = 1'b0;
    z_in_last  = 1'b0;
    compared++; if (z_cpu_enable !== 1'b0) begin mismatched++; $display("[TB] FAIL zd_enable_in_term: got %b, expected 0", z_cpu_enable); end
    tick();
    compared++; if (z_cpu_enable !== 1'b1) begin mismatched++; $display("[TB] FAIL zd_enable: got %b, expected 1", z_cpu_enable); end
    compared++; if (z_load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL zd_load_done: got %b, expected 1", z_load_done); end
    compared++; if (z_word_count !== 4'd2) begin mismatched++; $display("[TB] FAIL zd_word_count: got %0d, expected 2", z_word_count); end
    z_fetch_addr = 3'd0;
    tick();
    compared++; if (z_load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL zd_load_done_clear: got %b, expected 0", z_load_done); end
    compared++; if (z_fetch_data !== 8'h5A) begin mismatched++; $display("[TB] FAIL zd_mem[0]: got %h, expected 5a", z_fetch_data); end
    z_fetch_addr = 3'd1;
    tick();
    compared++; if (z_fetch_data !== 8'hFF) begin mismatched++; $display("[TB] FAIL zd_mem[1]: got %h, expected ff", z_fetch_data); end
    compared++; if (z_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL zd_overflow: got %b, expected 0", z_overflow); end
  endtask

  initial begin
    $display("[TB] program_loader directed tests");
    test_reset();
    test_basic_load();
    test_overflow();
    test_gapped_valid();
    test_reset_abort();
    test_back_to_back();
    test_fetch_collision();
    test_zero_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
